// File: rtl/sig_capture_pkg.sv
// sig_pkg: capture FSM state type shared by the sig_capture slice
package sig_pkg;
  typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, DONE} cap_state_t;
endpackage

// File: rtl/sig_capture_ram.sv
// capture_ram: simple dual-port RAM, one sync write port, one registered read port (read-before-write)
module capture_ram #(
  parameter int A_WIDTH = 9,
  parameter int D_WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_we,
  input  logic [A_WIDTH-1:0] i_wa,
  input  logic [D_WIDTH-1:0] i_wd,
  input  logic               i_re,
  input  logic [A_WIDTH-1:0] i_ra,
  output logic [D_WIDTH-1:0] o_rd
);
  logic [D_WIDTH-1:0] r_mem [2**A_WIDTH];
  logic [D_WIDTH-1:0] r_rd;
  always_ff @(posedge clk)
    if (i_we) r_mem[i_wa] <= i_wd;
  always_ff @(posedge clk)
    if (rst) r_rd <= '0;
    else if (i_re) r_rd <= r_mem[i_ra];
  assign o_rd = r_rd;
endmodule

// File: rtl/sig_capture.sv
// sig_capture: armed threshold trigger that records LENGTH strobed samples into a readable RAM frame
module sig_capture
  import sig_pkg::*;
#(
  parameter int A_WIDTH = 9,
  parameter int D_WIDTH = 8,
  parameter int LENGTH  = 256
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic               en,
  input  logic [D_WIDTH-1:0] thresh,
  input  logic [D_WIDTH-1:0] mic_signal,
  input  logic               rd,
  input  logic [A_WIDTH-1:0] rd_addr,
  output logic [D_WIDTH-1:0] rd_data,
  output logic               busy,
  output logic               done,
  output logic [A_WIDTH:0]   count
);
  localparam logic [A_WIDTH:0] L = (A_WIDTH+1)'(LENGTH);
  if (LENGTH < 1 || LENGTH > 2**A_WIDTH) begin : g_len_chk
    $error("sig_capture: LENGTH out of range");
  end
  cap_state_t         r_state, w_nxt;
  logic               r_busy, r_done;
  logic [A_WIDTH:0]   r_count, w_cnt_nx;
  logic [A_WIDTH-1:0] r_wr_ptr;
  logic               w_arm, w_we, w_last;
  assign w_cnt_nx = r_count + 1'b1;
  assign w_arm    = !abort && start && (r_state == IDLE || r_state == DONE);
  assign w_we     = !abort && en && ((r_state == ARMED && mic_signal >= thresh) || r_state == CAPTURE);
  assign w_last   = w_we && w_cnt_nx == L;
  assign w_nxt    = abort ? IDLE :
                    w_arm ? ARMED :
                    w_last ? DONE :
                    (w_we && r_state == ARMED) ? CAPTURE : r_state;
  always_ff @(posedge clk)
    if (rst) begin
      r_state  <= IDLE;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_count  <= '0;
      r_wr_ptr <= '0;
    end else begin
      r_state <= w_nxt;
      r_busy  <= w_nxt == ARMED || w_nxt == CAPTURE;
      r_done  <= w_nxt == DONE;
      if (w_arm) begin
        r_count  <= '0;
        r_wr_ptr <= '0;
      end else if (w_we) begin
        r_count <= w_cnt_nx;
        if (!w_last) r_wr_ptr <= r_wr_ptr + 1'b1;
      end
    end
  capture_ram #(.A_WIDTH(A_WIDTH), .D_WIDTH(D_WIDTH)) u_ram (
    .clk  (clk),
    .rst  (rst),
    .i_we (w_we),
    .i_wa (r_wr_ptr),
    .i_wd (mic_signal),
    .i_re (rd),
    .i_ra (rd_addr),
    .o_rd (rd_data)
  );
  assign busy  = r_busy;
  assign done  = r_done;
  assign count = r_count;
endmodule

// File: tb/tb_sig_capture.sv
// tb_sig_capture: directed self-checking bench for sig_capture (LENGTH=8 and LENGTH=16 instances)
module tb_sig_capture;
  logic       clk = 0, rst = 1, start = 0, abort = 0, en = 0, rd = 0;
  logic [7:0] thresh = 0, mic = 0;
  logic [3:0] rd_addr = 0;
  logic [7:0] rd_data, rd_data16;
  logic       busy, done, busy16, done16;
  logic [4:0] count, count16;
  int n_run = 0, n_fail = 0;
  int exp_cnt;
  always #5 clk = ~clk;
  sig_capture #(.A_WIDTH(4), .D_WIDTH(8), .LENGTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .en(en), .thresh(thresh),
    .mic_signal(mic), .rd(rd), .rd_addr(rd_addr), .rd_data(rd_data),
    .busy(busy), .done(done), .count(count));
  sig_capture #(.A_WIDTH(4), .D_WIDTH(8), .LENGTH(16)) dut16 (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .en(en), .thresh(thresh),
    .mic_signal(mic), .rd(rd), .rd_addr(rd_addr), .rd_data(rd_data16),
    .busy(busy16), .done(done16), .count(count16));
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  initial begin
    step(); step();
    rst = 0;
    chk("rst_busy", busy, 0); chk("rst_done", done, 0);
    chk("rst_count", count, 0); chk("rst_rd", rd_data, 0);
    thresh = 8'h80; en = 1; start = 1;
    step();
    start = 0;
    chk("arm_busy", busy, 1);
    for (int k = 0; k <= 32; k++) begin
      mic = 8'h70 + 8'(k);
      step();
      chk("ramp_count", count, k < 16 ? 0 : (k > 23 ? 8 : k - 15));
      chk("ramp_done", done, k >= 23);
      chk("ramp_busy", busy, k < 23);
    end
    en = 0; rd = 1;
    for (int a = 0; a < 8; a++) begin
      rd_addr = 4'(a);
      step();
      chk("ramp_rd", rd_data, 8'h80 + a);
    end
    rd = 0; rd_addr = 0;
    step();
    chk("rd_hold", rd_data, 8'h87);
    thresh = 8'h10; start = 1;
    step();
    start = 0;
    chk("re_arm_done", done, 0); chk("re_arm_busy", busy, 1); chk("re_arm_count", count, 0);
    en = 1; mic = 8'h20;
    step();
    chk("strobe_trig", count, 1);
    exp_cnt = 1;
    for (int c = 0; c <= 20; c++) begin
      en = (c % 3 == 2); mic = 8'h40 + 8'(c);
      if (en) exp_cnt++;
      step();
      chk("strobe_count", count, exp_cnt);
      chk("strobe_done", done, exp_cnt == 8);
    end
    en = 1; mic = 8'hEE;
    step(); step(); step();
    chk("strobe_hold_count", count, 8); chk("strobe_hold_done", done, 1);
    en = 0; rd = 1; rd_addr = 7;
    step();
    chk("strobe_rd7", rd_data, 8'h54);
    rd = 0; start = 1;
    step();
    start = 0; en = 1;
    mic = 8'h11; step();
    mic = 8'h12; step();
    mic = 8'h13; step();
    chk("pre_abort_count", count, 3);
    abort = 1; mic = 8'h99;
    step();
    abort = 0;
    chk("abort_busy", busy, 0); chk("abort_done", done, 0); chk("abort_count", count, 3);
    step();
    chk("abort_idle_count", count, 3);
    en = 0; rd = 1; rd_addr = 3;
    step();
    chk("abort_no_write", rd_data, 8'h48);
    rd = 0; start = 1;
    step();
    start = 0;
    chk("rearm_count", count, 0); chk("rearm_busy", busy, 1);
    en = 1; mic = 8'h05;
    step();
    chk("below_thresh", count, 0);
    mic = 8'h30;
    step();
    chk("fresh_trig", count, 1);
    en = 0; rd = 1; rd_addr = 0;
    step();
    chk("fresh_rd0", rd_data, 8'h30);
    rd = 0; start = 1; en = 1;
    for (int i = 1; i <= 7; i++) begin
      mic = 8'h30 + 8'(i);
      step();
      chk("start_ign_count", count, 1 + i);
      chk("start_ign_done", done, i == 7);
    end
    en = 0;
    step();
    start = 0;
    chk("done_rearm_done", done, 0); chk("done_rearm_busy", busy, 1); chk("done_rearm_count", count, 0);
    en = 1; mic = 8'hA5; rd = 1; rd_addr = 0;
    step();
    chk("rbw_old", rd_data, 8'h30); chk("rbw_count", count, 1);
    en = 0;
    step();
    chk("rbw_new", rd_data, 8'hA5);
    rd = 0; rst = 1;
    step(); step();
    rst = 0;
    chk("mid_rst_busy", busy, 0); chk("mid_rst_done", done, 0);
    chk("mid_rst_count", count, 0); chk("mid_rst_rd", rd_data, 0);
    rd = 1; rd_addr = 0;
    step();
    chk("mid_rst_keep", rd_data, 8'hA5);
    rd = 0; start = 1;
    step();
    start = 0; en = 1;
    for (int i = 0; i < 20; i++) begin
      mic = 8'h60 + 8'(i);
      step();
      chk("full_count", count16, i < 15 ? i + 1 : 16);
      chk("full_done", done16, i >= 15);
      chk("full_busy", busy16, i < 15);
    end
    chk("full_small_count", count, 8);
    en = 0; rd = 1; rd_addr = 0;
    step();
    chk("full_rd0", rd_data16, 8'h60);
    rd_addr = 15;
    step();
    chk("full_rd15", rd_data16, 8'h6F);
    rd = 0;
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
